// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer
//   Produces the synchronous active-high reset and the run window for the
//   pipelined mips core. The external asynchronous active-low reset is
//   synchronised on release, the core is held in reset for HOLD_CYCLES, then
//   a run window opens that counts executed cycles. The window closes on
//   halt_req or when the MAX_CYCLES budget runs out.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low external reset
//   soft_rst_req in   sync level, restart the core (re-enter HOLD)
//   halt_req     in   sync level, close the run window
//   cpu_reset    out  synchronous active-high reset to the core
//   run          out  high while the core executes (state RUN)
//   cycle_cnt    out  cycles spent in RUN since the last (soft) reset, saturating
//   timeout      out  sticky, run budget exhausted
//   state        out  IDLE=00 HOLD=01 RUN=10 HALT=11
module cpu_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 10000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_rst_req,
  input  logic             halt_req,
  output logic             cpu_reset,
  output logic             run,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             timeout,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam bit               TO_EN     = (MAX_CYCLES != 0);

  state_t                  st;
  logic [SYNC_STAGES-1:0]  sync_pipe;
  logic                    rst_sync;
  logic [HC_W-1:0]         hold_cnt;
  logic                    to_hit;
  logic                    soft_restart;

  assign state = st;

  // Release synchroniser: assertion is asynchronous, release ripples a 1
  // through the chain so the FSM only ever sees a clean, clock-aligned edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_sync = sync_pipe[SYNC_STAGES-1];

  // Budget edge: this RUN edge would make the count reach MAX_CYCLES.
  assign to_hit = TO_EN && (cycle_cnt == MAX_LAST);

  // Soft restart is meaningless before the synchroniser has released.
  assign soft_restart = soft_rst_req && (st != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      hold_cnt  <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
      cpu_reset <= 1'b1;
      run       <= 1'b0;
    end else if (soft_restart) begin
      st        <= HOLD;
      hold_cnt  <= '0;
      cycle_cnt <= '0;
      timeout   <= 1'b0;
      cpu_reset <= 1'b1;
      run       <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (rst_sync) begin
            st       <= HOLD;
            hold_cnt <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            st        <= RUN;
            cycle_cnt <= '0;
            cpu_reset <= 1'b0;
            run       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          // Budget expiry outranks halt only in what it records; both park.
          if (to_hit) begin
            st        <= HALT;
            cycle_cnt <= MAX_C;
            timeout   <= 1'b1;
            cpu_reset <= 1'b1;
            run       <= 1'b0;
          end else if (halt_req) begin
            st        <= HALT;
            cpu_reset <= 1'b1;
            run       <= 1'b0;
          end else if (cycle_cnt != CNT_SAT) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        HALT: begin
          // Parked: everything frozen until soft restart or reset.
        end
        default: begin
          st        <= IDLE;
          cpu_reset <= 1'b1;
          run       <= 1'b0;
        end
      endcase
    end
  end

endmodule
